// File: rtl/wb_uart_if.sv
// Wishbone classic bus bundle between the SoC interconnect and the wb_uart slave.
interface wb_uart_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [1:0]  wb_adr_i;
    logic [15:0] wb_dat_i;
    logic [15:0] wb_dat_o;
    logic        wb_ack_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/wb_uart.sv
// 16-bit Wishbone UART with 4-deep TX/RX FIFOs and programmable divisor, 8N1 by default.
// Define UART_PARITY_EN for 8E1 framing with RX parity checking (STATUS b5).

module wb_uart_fifo #(
    parameter int AW = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic       empty,
    output logic       full
);
    localparam int DEPTH = 1 << AW;

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;
    logic        pop_ok;
    logic        push_ok;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    // Pop is evaluated first, so a push into a full FIFO succeeds if a pop frees a slot.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign head    = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end
endmodule

module wb_uart #(
    parameter int          FIFO_AW   = 2,
    parameter logic [15:0] DIV_RESET = 16'd1084
) (
    input  logic       clk,
    input  logic       rst_n,
    wb_uart_if.slave   bus,
    input  logic       uart_rx,
    output logic       uart_tx,
    output logic       irq_o
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    // Bus side
    logic        ack_reg;
    logic [15:0] dat_reg;
    logic [15:0] div_reg;
    logic [15:0] rdata;
    logic [15:0] status;
    logic        req;
    logic        wr;
    logic        rd;
    logic        stat_wr;

    // FIFOs
    logic        tx_push;
    logic        tx_pop;
    logic [7:0]  tx_head;
    logic        tx_empty;
    logic        tx_full;
    logic        rx_push;
    logic        rx_pop;
    logic [7:0]  rx_head;
    logic        rx_empty;
    logic        rx_full;
    logic        rx_drop;

    // Flags
    logic        rx_ovr_reg;
    logic        frm_err_reg;
    logic        frm_set;
    logic        par_bit;
`ifdef UART_PARITY_EN
    logic        par_err_reg;
    logic        par_set;
    logic        tx_par_reg;
    logic        tx_par_next;
`endif

    // TX engine
    state_t      tx_state_reg;
    state_t      tx_state_next;
    logic [15:0] tx_cnt_reg;
    logic [15:0] tx_cnt_next;
    logic [2:0]  tx_bit_reg;
    logic [2:0]  tx_bit_next;
    logic [7:0]  tx_shift_reg;
    logic [7:0]  tx_shift_next;
    logic        tx_line_reg;
    logic        tx_line_next;
    logic        tx_load;
    logic        tx_idle;

    // RX engine
    state_t      rx_state_reg;
    state_t      rx_state_next;
    logic [15:0] rx_cnt_reg;
    logic [15:0] rx_cnt_next;
    logic [2:0]  rx_bit_reg;
    logic [2:0]  rx_bit_next;
    logic [7:0]  rx_shift_reg;
    logic [7:0]  rx_shift_next;
    logic        rx_meta_reg;
    logic        rx_sync_reg;
    logic        rx_prev_reg;
    logic [15:0] half_bit;

    assign req     = bus.wb_cyc_i & bus.wb_stb_i & ~ack_reg;
    assign wr      = req & bus.wb_we_i;
    assign rd      = req & ~bus.wb_we_i;
    assign tx_push = wr & (bus.wb_adr_i == 2'd0);
    assign rx_pop  = rd & (bus.wb_adr_i == 2'd0);
    assign stat_wr = wr & (bus.wb_adr_i == 2'd1);

    assign bus.wb_ack_o = ack_reg;
    assign bus.wb_dat_o = dat_reg;
    assign uart_tx      = tx_line_reg;
    assign irq_o        = ~rx_empty;
    assign tx_idle      = tx_empty & (tx_state_reg == S_IDLE);
    assign rx_drop      = rx_push & rx_full & ~(rx_pop & ~rx_empty);

`ifdef UART_PARITY_EN
    assign par_bit = par_err_reg;
`else
    assign par_bit = 1'b0;
`endif

    assign status = {10'd0, par_bit, frm_err_reg, rx_ovr_reg, tx_idle, tx_full, ~rx_empty};

    always_comb begin
        rdata = 16'h0000;
        case (bus.wb_adr_i)
            2'd0:    rdata = rx_empty ? 16'h0000 : {8'h00, rx_head};
            2'd1:    rdata = status;
            2'd2:    rdata = div_reg;
            default: rdata = 16'h0000;
        endcase
    end

    wb_uart_fifo #(.AW(FIFO_AW)) u_tx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (tx_push),
        .push_data (bus.wb_dat_i[7:0]),
        .pop       (tx_pop),
        .head      (tx_head),
        .empty     (tx_empty),
        .full      (tx_full)
    );

    wb_uart_fifo #(.AW(FIFO_AW)) u_rx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rx_push),
        .push_data (rx_shift_reg),
        .pop       (rx_pop),
        .head      (rx_head),
        .empty     (rx_empty),
        .full      (rx_full)
    );

    // Bus registers and sticky flags; a set in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_reg     <= 1'b0;
            dat_reg     <= 16'h0000;
            div_reg     <= DIV_RESET;
            rx_ovr_reg  <= 1'b0;
            frm_err_reg <= 1'b0;
`ifdef UART_PARITY_EN
            par_err_reg <= 1'b0;
`endif
        end else begin
            ack_reg     <= req;
            dat_reg     <= rd ? rdata : 16'h0000;
            if (wr && bus.wb_adr_i == 2'd2) div_reg <= bus.wb_dat_i;
            rx_ovr_reg  <= (rx_ovr_reg  & ~(stat_wr & bus.wb_dat_i[3])) | rx_drop;
            frm_err_reg <= (frm_err_reg & ~(stat_wr & bus.wb_dat_i[4])) | frm_set;
`ifdef UART_PARITY_EN
            par_err_reg <= (par_err_reg & ~(stat_wr & bus.wb_dat_i[5])) | par_set;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_reg <= S_IDLE;
            tx_cnt_reg   <= 16'd0;
            tx_bit_reg   <= 3'd0;
            tx_shift_reg <= 8'h00;
            tx_line_reg  <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par_reg   <= 1'b0;
`endif
        end else begin
            tx_state_reg <= tx_state_next;
            tx_cnt_reg   <= tx_cnt_next;
            tx_bit_reg   <= tx_bit_next;
            tx_shift_reg <= tx_shift_next;
            tx_line_reg  <= tx_line_next;
`ifdef UART_PARITY_EN
            tx_par_reg   <= tx_par_next;
`endif
        end
    end

    always_comb begin
        tx_state_next = tx_state_reg;
        tx_cnt_next   = tx_cnt_reg;
        tx_bit_next   = tx_bit_reg;
        tx_shift_next = tx_shift_reg;
        tx_pop        = 1'b0;
        tx_load       = 1'b0;
        tx_line_next  = 1'b1;
`ifdef UART_PARITY_EN
        tx_par_next   = tx_par_reg;
`endif
        if (tx_state_reg == S_IDLE) begin
            tx_load = ~tx_empty;
        end else if (tx_cnt_reg != 16'd0) begin
            tx_cnt_next = tx_cnt_reg - 16'd1;
        end else begin
            tx_cnt_next = div_reg;
            case (tx_state_reg)
                S_START: begin
                    tx_state_next = S_DATA;
                    tx_bit_next   = 3'd0;
                end
                S_DATA: begin
                    tx_shift_next = {1'b0, tx_shift_reg[7:1]};
                    tx_bit_next   = tx_bit_reg + 3'd1;
                    if (tx_bit_reg == 3'd7) begin
`ifdef UART_PARITY_EN
                        tx_state_next = S_PARITY;
`else
                        tx_state_next = S_STOP;
`endif
                    end
                end
`ifdef UART_PARITY_EN
                S_PARITY: tx_state_next = S_STOP;
`endif
                S_STOP: begin
                    // Chain straight into the next start bit when more data is queued.
                    tx_load = ~tx_empty;
                    if (tx_empty) tx_state_next = S_IDLE;
                end
                default: tx_state_next = S_IDLE;
            endcase
        end
        if (tx_load) begin
            tx_state_next = S_START;
            tx_pop        = 1'b1;
            tx_shift_next = tx_head;
            tx_cnt_next   = div_reg;
`ifdef UART_PARITY_EN
            tx_par_next   = ^tx_head;
`endif
        end
        case (tx_state_next)
            S_START:  tx_line_next = 1'b0;
            S_DATA:   tx_line_next = tx_shift_next[0];
`ifdef UART_PARITY_EN
            S_PARITY: tx_line_next = tx_par_next;
`endif
            default:  tx_line_next = 1'b1;
        endcase
    end

    // First wait after the start edge is half a bit so later samples land mid-bit.
    assign half_bit = {1'b0, div_reg[15:1]} + {15'd0, div_reg[0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_reg  <= 1'b1;
            rx_sync_reg  <= 1'b1;
            rx_prev_reg  <= 1'b1;
            rx_state_reg <= S_IDLE;
            rx_cnt_reg   <= 16'd0;
            rx_bit_reg   <= 3'd0;
            rx_shift_reg <= 8'h00;
        end else begin
            rx_meta_reg  <= uart_rx;
            rx_sync_reg  <= rx_meta_reg;
            rx_prev_reg  <= rx_sync_reg;
            rx_state_reg <= rx_state_next;
            rx_cnt_reg   <= rx_cnt_next;
            rx_bit_reg   <= rx_bit_next;
            rx_shift_reg <= rx_shift_next;
        end
    end

    always_comb begin
        rx_state_next = rx_state_reg;
        rx_cnt_next   = rx_cnt_reg;
        rx_bit_next   = rx_bit_reg;
        rx_shift_next = rx_shift_reg;
        rx_push       = 1'b0;
        frm_set       = 1'b0;
`ifdef UART_PARITY_EN
        par_set       = 1'b0;
`endif
        if (rx_state_reg == S_IDLE) begin
            if (rx_prev_reg && !rx_sync_reg) begin
                rx_state_next = S_START;
                rx_cnt_next   = (half_bit == 16'd0) ? 16'd0 : half_bit - 16'd1;
            end
        end else if (rx_cnt_reg != 16'd0) begin
            rx_cnt_next = rx_cnt_reg - 16'd1;
        end else begin
            rx_cnt_next = div_reg;
            case (rx_state_reg)
                S_START: begin
                    rx_state_next = rx_sync_reg ? S_IDLE : S_DATA;
                    rx_bit_next   = 3'd0;
                end
                S_DATA: begin
                    rx_shift_next = {rx_sync_reg, rx_shift_reg[7:1]};
                    rx_bit_next   = rx_bit_reg + 3'd1;
                    if (rx_bit_reg == 3'd7) begin
`ifdef UART_PARITY_EN
                        rx_state_next = S_PARITY;
`else
                        rx_state_next = S_STOP;
`endif
                    end
                end
`ifdef UART_PARITY_EN
                S_PARITY: begin
                    par_set       = rx_sync_reg ^ (^rx_shift_reg);
                    rx_state_next = S_STOP;
                end
`endif
                S_STOP: begin
                    rx_push       = 1'b1;
                    frm_set       = ~rx_sync_reg;
                    rx_state_next = S_IDLE;
                end
                default: rx_state_next = S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_uart.sv
// Scoreboard bench for wb_uart: TX frames decoded by a line monitor, RX bytes checked on DATA reads.
module tb_wb_uart;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic uart_rx = 1'b1;
    logic uart_tx;
    logic irq_o;

    wb_uart_if bus();

    wb_uart #(.FIFO_AW(2), .DIV_RESET(16'd1084)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .uart_rx (uart_rx),
        .uart_tx (uart_tx),
        .irq_o   (irq_o)
    );

    always #5 clk = ~clk;

    int          checks_total = 0;
    int          checks_passed = 0;
    int          tx_frames = 0;
    bit          tx_mon_en = 1'b0;
    logic [7:0]  tx_q[$];
    logic [7:0]  rx_q[$];
    logic [7:0]  mon_byte;
    logic [15:0] rd_data;
    logic [15:0] dummy;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks_total++;
        if (got === exp) checks_passed++;
        else $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wb_cycle(input logic we, input logic [1:0] adr, input logic [15:0] wdat,
                            output logic [15:0] rdat);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = we;
        bus.wb_adr_i = adr;
        bus.wb_dat_i = wdat;
        wait_clk(1);
        check_eq("wb_ack", {15'd0, bus.wb_ack_o}, 16'd1);
        rdat = bus.wb_dat_o;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        wait_clk(1);
    endtask

    task automatic wb_write(input logic [1:0] adr, input logic [15:0] wdat);
        wb_cycle(1'b1, adr, wdat, dummy);
        $display("wr adr=%0d data=0x%04h", adr, wdat);
    endtask

    task automatic read_check(input string tag, input logic [1:0] adr, input logic [15:0] mask,
                              input logic [15:0] exp);
        wb_cycle(1'b0, adr, 16'h0000, rd_data);
        $display("rd adr=%0d data=0x%04h", adr, rd_data);
        check_eq(tag, rd_data & mask, exp);
    endtask

    task automatic read_rx(input string tag);
        logic [7:0] exp;
        exp = (rx_q.size() != 0) ? rx_q.pop_front() : 8'h00;
        read_check(tag, 2'd0, 16'hFFFF, {8'h00, exp});
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip,
                              input logic expect_store);
        if (expect_store) rx_q.push_back(b);
        $display("rx frame 0x%02h stop=%0b par_flip=%0b", b, stop_bit, par_flip);
        uart_rx = 1'b0;
        wait_clk(4);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            wait_clk(4);
        end
`ifdef UART_PARITY_EN
        uart_rx = (^b) ^ par_flip;
        wait_clk(4);
`endif
        uart_rx = stop_bit;
        wait_clk(4);
        uart_rx = 1'b1;
        wait_clk(6);
    endtask

    task automatic wait_tx(input int n);
        for (int i = 0; i < 3000 && tx_frames < n; i++) wait_clk(1);
        check_eq("tx_frames", 16'(tx_frames), 16'(n));
    endtask

    // TX line monitor: samples each bit mid-way, 4 clk per bit with DIV=3.
    initial begin
        forever begin
            @(negedge uart_tx);
            if (tx_mon_en) begin
                repeat (2) @(negedge clk);
                check_eq("tx_start", {15'd0, uart_tx}, 16'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(negedge clk);
                    mon_byte[i] = uart_tx;
                end
`ifdef UART_PARITY_EN
                repeat (4) @(negedge clk);
                check_eq("tx_parity", {15'd0, uart_tx}, {15'd0, ^mon_byte});
`endif
                repeat (4) @(negedge clk);
                check_eq("tx_stop", {15'd0, uart_tx}, 16'd1);
                $display("tx frame 0x%02h", mon_byte);
                check_eq("tx_expected", 16'(tx_q.size() != 0), 16'd1);
                if (tx_q.size() != 0) check_eq("tx_byte", {8'h00, mon_byte}, {8'h00, tx_q.pop_front()});
                tx_frames++;
            end
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        bus.wb_adr_i = 2'd0;
        bus.wb_dat_i = 16'h0000;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(2);
        check_eq("rst_tx", {15'd0, uart_tx}, 16'd1);
        check_eq("rst_irq", {15'd0, irq_o}, 16'd0);
        check_eq("rst_ack", {15'd0, bus.wb_ack_o}, 16'd0);
        check_eq("rst_dat", bus.wb_dat_o, 16'h0000);

        // Start a frame, then reset in the middle of it.
        wb_write(2'd2, 16'd3);
        wb_write(2'd0, 16'h0000);
        wait_clk(12);
        check_eq("mid_tx_low", {15'd0, uart_tx}, 16'd0);
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_tx", {15'd0, uart_tx}, 16'd1);
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(1);
        read_check("rst_status", 2'd1, 16'hFFFF, 16'h0004);
        read_check("rst_div", 2'd2, 16'hFFFF, 16'd1084);
        check_eq("dat_idle", bus.wb_dat_o, 16'h0000);
        read_check("rx_empty_read", 2'd0, 16'hFFFF, 16'h0000);
        read_check("reg3_read", 2'd3, 16'hFFFF, 16'h0000);

        wb_write(2'd2, 16'd3);
        read_check("div_rw", 2'd2, 16'hFFFF, 16'd3);
        tx_mon_en = 1'b1;

        // Single byte
        tx_q.push_back(8'h55);
        wb_write(2'd0, 16'h0055);
        read_check("status_busy", 2'd1, 16'hFFFF, 16'h0000);
        wait_tx(1);
        wait_clk(4);
        read_check("status_tx_idle", 2'd1, 16'hFFFF, 16'h0004);

        // Burst: one byte goes straight to the shifter, four fill the FIFO, the sixth is dropped.
        for (int i = 0; i < 6; i++) begin
            if (i < 5) tx_q.push_back(8'(8'h10 + i));
            wb_write(2'd0, 16'(16'h0010 + i));
        end
        read_check("tx_full_set", 2'd1, 16'h0002, 16'h0002);
        wait_tx(2);
        wait_clk(4);
        read_check("tx_full_clear", 2'd1, 16'h0002, 16'h0000);
        wait_tx(6);
        check_eq("tx_q_drained", 16'(tx_q.size()), 16'd0);
        wait_clk(4);
        read_check("tx_done_status", 2'd1, 16'hFFFF, 16'h0004);

        // Receive one byte
        send_frame(8'hA3, 1'b1, 1'b0, 1'b1);
        check_eq("irq_set", {15'd0, irq_o}, 16'd1);
        read_rx("rx_a3");
        read_rx("rx_empty_after");
        check_eq("irq_clear", {15'd0, irq_o}, 16'd0);

        // Overflow: fifth frame dropped
        for (int i = 0; i < 5; i++) send_frame(8'(8'h60 + i), 1'b1, 1'b0, i < 4);
        read_check("ovr_set", 2'd1, 16'h0008, 16'h0008);
        wb_write(2'd1, 16'h0008);
        read_check("ovr_clear", 2'd1, 16'hFFFF, 16'h0005);
        for (int i = 0; i < 4; i++) read_rx("rx_ovr_data");
        read_rx("rx_ovr_empty");

        // Framing error: byte still stored
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        read_check("frm_set", 2'd1, 16'h0010, 16'h0010);
        read_rx("rx_frm_data");
        wb_write(2'd1, 16'h0010);
        read_check("frm_clear", 2'd1, 16'h0010, 16'h0000);

        // Short glitch must not start a frame
        uart_rx = 1'b0;
        wait_clk(2);
        uart_rx = 1'b1;
        wait_clk(60);
        check_eq("glitch_irq", {15'd0, irq_o}, 16'd0);
        read_check("glitch_status", 2'd1, 16'h0001, 16'h0000);

`ifdef UART_PARITY_EN
        send_frame(8'h5A, 1'b1, 1'b1, 1'b1);
        read_check("par_set", 2'd1, 16'h0020, 16'h0020);
        read_rx("rx_par_data");
        wb_write(2'd1, 16'h0020);
        read_check("par_clear", 2'd1, 16'h0020, 16'h0000);
`endif

        wait_clk(5);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
